// File: rtl/stb_datapath_if.sv
// Store buffer datapath bus: controller strobes, LSU store payload in,
// cache write request and occupancy status out.
interface stb_datapath_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Controller strobes and LSU store payload
  logic              stb_wr_en;
  logic              stb_r_en;
  logic              stb_initial_read;
  logic [ADDR_W-1:0] lsudbus2stb_addr;
  logic [DATA_W-1:0] lsudbus2stb_wdata;
  logic [SEL_W-1:0]  lsudbus2stb_sel;

  // Head entry presented to the data cache
  logic [ADDR_W-1:0] stb2dcache_addr;
  logic [DATA_W-1:0] stb2dcache_wdata;
  logic [SEL_W-1:0]  stb2dcache_sel;
  logic              stb2dcache_req;
  logic              stb2dcache_w_en;

  // Status back to the controller
  logic              stb_full;
  logic              stb_empty;
  logic [CNT_W-1:0]  stb_count;
  logic              stb_err;

  // Controller / LSU side
  modport master (
    output stb_wr_en, stb_r_en, stb_initial_read,
           lsudbus2stb_addr, lsudbus2stb_wdata, lsudbus2stb_sel,
    input  stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel,
           stb2dcache_req, stb2dcache_w_en,
           stb_full, stb_empty, stb_count, stb_err
  );

  // Store buffer datapath side
  modport slave (
    input  stb_wr_en, stb_r_en, stb_initial_read,
           lsudbus2stb_addr, lsudbus2stb_wdata, lsudbus2stb_sel,
    output stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel,
           stb2dcache_req, stb2dcache_w_en,
           stb_full, stb_empty, stb_count, stb_err
  );
endinterface

// File: rtl/stb_datapath.sv
// Store buffer datapath: circular entry storage that accepts LSU stores and
// drains them in FIFO order to the data cache, one entry per read strobe.
module stb_datapath #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  stb_datapath_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic              full, empty;
  logic              push, pop;
  entry_t            head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A push is refused when full; a pop needs an outstanding request and data.
  assign push = bus.stb_wr_en & ~full;
  assign pop  = bus.stb_r_en & req_q & ~empty;

  // Next-state for pointers, occupancy, request and sticky error.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Keep requesting while anything is left; the controller kicks the first one.
    req_d = bus.stb_initial_read | (count_d != '0);
    if ((bus.stb_wr_en & full) | (bus.stb_r_en & (empty | ~req_q)))
      err_d = 1'b1;
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      req_q    <= req_d;
      err_q    <= err_d;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  // NOTE: the array is reset on purpose so the cache outputs read back zero
  // after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{addr: bus.lsudbus2stb_addr,
                           data: bus.lsudbus2stb_wdata,
                           sel:  bus.lsudbus2stb_sel};
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.stb2dcache_addr  = head.addr;
  assign bus.stb2dcache_wdata = head.data;
  assign bus.stb2dcache_sel   = head.sel;
  assign bus.stb2dcache_req   = req_q;
  assign bus.stb2dcache_w_en  = req_q;
  assign bus.stb_full         = full;
  assign bus.stb_empty        = empty;
  assign bus.stb_count        = count_q;
  assign bus.stb_err          = err_q;
endmodule

// File: tb/tb_stb_datapath.sv
// Self-checking bench for stb_datapath: directed scenarios plus a randomized
// run, all compared against a queue-based model of the store buffer.
module tb_stb_datapath;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
  } entry_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Reference model: a plain FIFO queue plus request/error bits and
  // running pointer positions.
  entry_t m_q[$];
  bit     m_req;
  bit     m_err;
  int     m_wr_idx;
  int     m_rd_idx;

  stb_datapath_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  stb_datapath #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic void model_clear();
    m_q.delete();
    m_req    = 1'b0;
    m_err    = 1'b0;
    m_wr_idx = 0;
    m_rd_idx = 0;
  endfunction

  function automatic void model_step(bit wr, bit rd, bit init, entry_t e);
    bit is_full  = (m_q.size() == DEPTH);
    bit is_empty = (m_q.size() == 0);
    bit take_push = wr && !is_full;
    bit take_pop  = rd && m_req && !is_empty;
    if ((wr && is_full) || (rd && (is_empty || !m_req))) m_err = 1'b1;
    if (take_pop) begin
      void'(m_q.pop_front());
      m_rd_idx = (m_rd_idx + 1) % DEPTH;
    end
    if (take_push) begin
      m_q.push_back(e);
      m_wr_idx = (m_wr_idx + 1) % DEPTH;
    end
    m_req = init || (m_q.size() != 0);
  endfunction

  task automatic idle_inputs();
    bus.stb_wr_en         = 1'b0;
    bus.stb_r_en          = 1'b0;
    bus.stb_initial_read  = 1'b0;
    bus.lsudbus2stb_addr  = '0;
    bus.lsudbus2stb_wdata = '0;
    bus.lsudbus2stb_sel   = '0;
  endtask

  // Drive one clock of controller activity; returns on the falling edge.
  task automatic cycle(input bit wr, input bit rd, input bit init,
                       input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d,
                       input logic [SEL_W-1:0] s);
    entry_t e;
    e = '{addr: a, data: d, sel: s};
    bus.stb_wr_en         = wr;
    bus.stb_r_en          = rd;
    bus.stb_initial_read  = init;
    bus.lsudbus2stb_addr  = a;
    bus.lsudbus2stb_wdata = d;
    bus.lsudbus2stb_sel   = s;
    @(posedge clk);
    model_step(wr, rd, init, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.stb_count !== '0) begin n_fail++; $display("FAIL reset count: got %0d want 0", bus.stb_count); end
    n_checks++; if (bus.stb_empty !== 1'b1) begin n_fail++; $display("FAIL reset empty: got %b want 1", bus.stb_empty); end
    n_checks++; if (bus.stb_full !== 1'b0) begin n_fail++; $display("FAIL reset full: got %b want 0", bus.stb_full); end
    n_checks++; if ({bus.stb2dcache_req, bus.stb2dcache_w_en} !== 2'b00) begin n_fail++; $display("FAIL reset req/w_en: got %b%b want 00", bus.stb2dcache_req, bus.stb2dcache_w_en); end
    n_checks++; if ({bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel} !== '0) begin n_fail++; $display("FAIL reset cache outputs: got %h/%h/%h want 0", bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel); end
    n_checks++; if (bus.stb_err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", bus.stb_err); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_first_push();
    do_reset();
    cycle(1, 0, 1, 32'h100, 32'hAA, 4'hF);
    n_checks++; if (bus.stb_count !== CNT_W'(1)) begin n_fail++; $display("FAIL first_push count: got %0d want 1", bus.stb_count); end
    n_checks++; if (bus.stb_empty !== 1'b0) begin n_fail++; $display("FAIL first_push empty: got %b want 0", bus.stb_empty); end
    n_checks++; if ({bus.stb2dcache_req, bus.stb2dcache_w_en} !== 2'b11) begin n_fail++; $display("FAIL first_push req/w_en: got %b%b want 11", bus.stb2dcache_req, bus.stb2dcache_w_en); end
    n_checks++; if ({bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel} !== {32'h100, 32'hAA, 4'hF}) begin n_fail++; $display("FAIL first_push head: got %h/%h/%h want 100/aa/f", bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 0, i == 0, 32'h200 + 32'(i * 4), $urandom, SEL_W'($urandom));
    n_checks++; if (bus.stb_full !== 1'b1) begin n_fail++; $display("FAIL fill full: got %b want 1", bus.stb_full); end
    n_checks++; if (bus.stb_count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL fill count: got %0d want %0d", bus.stb_count, DEPTH); end
    n_checks++; if (bus.stb_err !== 1'b0) begin n_fail++; $display("FAIL fill err before overflow: got %b want 0", bus.stb_err); end
    cycle(1, 0, 0, 32'hDEAD, 32'hBEEF, 4'h3);
    n_checks++; if (bus.stb_err !== 1'b1) begin n_fail++; $display("FAIL overflow err: got %b want 1", bus.stb_err); end
    n_checks++; if (bus.stb_count !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL overflow count: got %0d want %0d", bus.stb_count, DEPTH); end
    n_checks++; if (bus.stb2dcache_addr !== 32'h200) begin n_fail++; $display("FAIL overflow head addr: got %h want 200", bus.stb2dcache_addr); end
    // Drain everything and confirm the overflowing store never entered.
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (bus.stb2dcache_addr !== 32'h200 + 32'(i * 4)) begin n_fail++; $display("FAIL overflow drain %0d addr: got %h want %h", i, bus.stb2dcache_addr, 32'h200 + 32'(i * 4)); end
      cycle(0, 1, 0, '0, '0, '0);
    end
    n_checks++; if ({bus.stb_empty, bus.stb2dcache_req} !== 2'b10) begin n_fail++; $display("FAIL overflow drained empty/req: got %b%b want 10", bus.stb_empty, bus.stb2dcache_req); end
  endtask

  task automatic test_drain_order();
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1, 0, i == 0, 32'h300 + 32'(i * 4), 32'(i), 4'hF);
    n_checks++; if ({bus.stb2dcache_req, bus.stb2dcache_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL drain start req/addr: got %b/%h want 1/300", bus.stb2dcache_req, bus.stb2dcache_addr); end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, '0, '0, '0);
      if (k < 2) begin
        n_checks++; if ({bus.stb2dcache_req, bus.stb2dcache_addr} !== {1'b1, 32'h300 + 32'((k + 1) * 4)}) begin n_fail++; $display("FAIL drain pop %0d req/addr: got %b/%h want 1/%h", k, bus.stb2dcache_req, bus.stb2dcache_addr, 32'h300 + 32'((k + 1) * 4)); end
      end else begin
        n_checks++; if ({bus.stb2dcache_req, bus.stb_empty} !== 2'b01) begin n_fail++; $display("FAIL drain last req/empty: got %b%b want 01", bus.stb2dcache_req, bus.stb_empty); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1, 0, i == 0, 32'h400 + 32'(i * 4), $urandom, SEL_W'($urandom));
    for (int c = 0; c < 10; c++) begin
      cycle(1, 1, 0, 32'h440 + 32'(c * 4), $urandom, SEL_W'($urandom));
      n_checks++; if (bus.stb_count !== CNT_W'(4)) begin n_fail++; $display("FAIL b2b cycle %0d count: got %0d want 4", c, bus.stb_count); end
      n_checks++; if ({bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel} !== m_q[0]) begin n_fail++; $display("FAIL b2b cycle %0d head: got %h/%h/%h want %h", c, bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel, m_q[0]); end
    end
    n_checks++; if (int'(dut.wr_ptr_q) !== m_wr_idx) begin n_fail++; $display("FAIL b2b wr_ptr: got %0d want %0d", dut.wr_ptr_q, m_wr_idx); end
    n_checks++; if (int'(dut.rd_ptr_q) !== m_rd_idx) begin n_fail++; $display("FAIL b2b rd_ptr: got %0d want %0d", dut.rd_ptr_q, m_rd_idx); end
  endtask

  task automatic test_empty_pop();
    do_reset();
    cycle(0, 1, 0, '0, '0, '0);
    n_checks++; if (bus.stb_err !== 1'b1) begin n_fail++; $display("FAIL empty_pop err: got %b want 1", bus.stb_err); end
    n_checks++; if (bus.stb_count !== '0) begin n_fail++; $display("FAIL empty_pop count: got %0d want 0", bus.stb_count); end
    n_checks++; if ({int'(dut.wr_ptr_q), int'(dut.rd_ptr_q)} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL empty_pop pointers: got %0d/%0d want 0/0", dut.wr_ptr_q, dut.rd_ptr_q); end
    // Push and pop together into an empty buffer: push taken, pop rejected.
    do_reset();
    cycle(1, 1, 1, 32'h600, 32'h66, 4'h1);
    n_checks++; if ({bus.stb_count, bus.stb_err, bus.stb2dcache_req} !== {CNT_W'(1), 1'b1, 1'b1}) begin n_fail++; $display("FAIL empty_boundary count/err/req: got %0d/%b/%b want 1/1/1", bus.stb_count, bus.stb_err, bus.stb2dcache_req); end
    n_checks++; if (bus.stb2dcache_addr !== 32'h600) begin n_fail++; $display("FAIL empty_boundary addr: got %h want 600", bus.stb2dcache_addr); end
  endtask

  task automatic test_full_boundary();
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 0, i == 0, 32'h700 + 32'(i * 4), $urandom, SEL_W'($urandom));
    cycle(1, 1, 0, 32'h7F0, 32'h77, 4'h7);
    n_checks++; if ({bus.stb_count, bus.stb_err} !== {CNT_W'(DEPTH - 1), 1'b1}) begin n_fail++; $display("FAIL full_boundary count/err: got %0d/%b want %0d/1", bus.stb_count, bus.stb_err, DEPTH - 1); end
    n_checks++; if (bus.stb2dcache_addr !== 32'h704) begin n_fail++; $display("FAIL full_boundary head addr: got %h want 704", bus.stb2dcache_addr); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 5; i++)
      cycle(1, 0, i == 0, 32'h800 + 32'(i * 4), $urandom, SEL_W'($urandom));
    cycle(0, 1, 0, '0, '0, '0);
    bus.stb_r_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.stb_count, bus.stb_empty, bus.stb_full} !== {CNT_W'(0), 1'b1, 1'b0}) begin n_fail++; $display("FAIL mid_reset count/empty/full: got %0d/%b/%b want 0/1/0", bus.stb_count, bus.stb_empty, bus.stb_full); end
    n_checks++; if ({bus.stb2dcache_req, bus.stb2dcache_w_en, bus.stb_err} !== 3'b000) begin n_fail++; $display("FAIL mid_reset req/w_en/err: got %b%b%b want 000", bus.stb2dcache_req, bus.stb2dcache_w_en, bus.stb_err); end
    n_checks++; if ({bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel} !== '0) begin n_fail++; $display("FAIL mid_reset cache outputs: got %h/%h/%h want 0", bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n_checks++; if (bus.stb_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset release empty: got %b want 1", bus.stb_empty); end
    cycle(1, 0, 1, 32'h900, 32'h99, 4'h9);
    n_checks++; if ({bus.stb2dcache_addr, bus.stb_count} !== {32'h900, CNT_W'(1)}) begin n_fail++; $display("FAIL mid_reset repush addr/count: got %h/%0d want 900/1", bus.stb2dcache_addr, bus.stb_count); end
    n_checks++; if (dut.mem_q[0].addr !== 32'h900) begin n_fail++; $display("FAIL mid_reset repush index0 addr: got %h want 900", dut.mem_q[0].addr); end
  endtask

  task automatic test_random();
    bit wr, rd, init;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      wr   = ($urandom_range(0, 99) < 55) && (m_q.size() < DEPTH);
      rd   = m_req && (m_q.size() != 0) && ($urandom_range(0, 99) < 50);
      init = wr && (m_q.size() == 0);
      cycle(wr, rd, init, $urandom, $urandom, SEL_W'($urandom));
      n_checks++; if (int'(bus.stb_count) !== m_q.size()) begin n_fail++; $display("FAIL random %0d count: got %0d want %0d", c, bus.stb_count, m_q.size()); end
      n_checks++; if ({bus.stb_full, bus.stb_empty} !== {m_q.size() == DEPTH, m_q.size() == 0}) begin n_fail++; $display("FAIL random %0d full/empty: got %b%b want %b%b", c, bus.stb_full, bus.stb_empty, m_q.size() == DEPTH, m_q.size() == 0); end
      n_checks++; if ({bus.stb2dcache_req, bus.stb2dcache_w_en, bus.stb_err} !== {m_req, m_req, m_err}) begin n_fail++; $display("FAIL random %0d req/w_en/err: got %b%b%b want %b%b%b", c, bus.stb2dcache_req, bus.stb2dcache_w_en, bus.stb_err, m_req, m_req, m_err); end
      if (m_q.size() != 0) begin
        n_checks++; if ({bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel} !== m_q[0]) begin n_fail++; $display("FAIL random %0d head: got %h/%h/%h want %h", c, bus.stb2dcache_addr, bus.stb2dcache_wdata, bus.stb2dcache_sel, m_q[0]); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    model_clear();
    idle_inputs();
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_drain_order();
    test_back_to_back();
    test_empty_pop();
    test_full_boundary();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stb_datapath.md
# stb_datapath

Circular storage for the store buffer. It accepts stores from the LSU data bus under control of the store buffer controller and presents the oldest entry to the data cache as a write request. It sits between the controller and the data cache: it consumes the controller's `stb_wr_en`, `stb_r_en` and `stb_initial_read`, and returns `stb_full` and `stb_empty` to it. Entries drain to the cache in FIFO order, one per controller read strobe.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; a power of two, at least 2.
- `ADDR_W`, default 32: store address width.
- `DATA_W`, default 32: store data width; `DATA_W/8` byte selects.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `stb_wr_en` in 1: push the LSU store (from the controller).
- `stb_r_en` in 1: pop the head entry (from the controller, on cache acknowledge).
- `stb_initial_read` in 1: kick a cache request for a store entering an empty buffer.
- `lsudbus2stb_addr` in `ADDR_W`: store address.
- `lsudbus2stb_wdata` in `DATA_W`: store data.
- `lsudbus2stb_sel` in `DATA_W/8`: byte selects.
- `stb2dcache_addr` out `ADDR_W`: head entry address.
- `stb2dcache_wdata` out `DATA_W`: head entry data.
- `stb2dcache_sel` out `DATA_W/8`: head entry byte selects.
- `stb2dcache_req` out 1: cache write request, registered.
- `stb2dcache_w_en` out 1: equal to `stb2dcache_req`.
- `stb_full` out 1: count equals `DEPTH`.
- `stb_empty` out 1: count equals 0.
- `stb_count` out `$clog2(DEPTH)+1`: occupancy.
- `stb_err` out 1: sticky protocol error flag.

## Operation
- **State:**
  - Entry array of {addr, data, sel}, `DEPTH` deep.
  - `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits, wrap modulo `DEPTH`.
  - `count`, `$clog2(DEPTH)+1` bits.
  - `req_q`.
  - `err_q`.
- **Push:**
  - Condition: `stb_wr_en` and not `stb_full`.
  - Writes the LSU addr/data/sel into `entry[wr_ptr]`.
  - Increments `wr_ptr`; it wraps from `DEPTH-1` to 0.
- **Pop:**
  - Condition: `stb_r_en` and `req_q` and not `stb_empty`.
  - Increments `rd_ptr` with wrap.
- **count_next:** `count + push - pop`. A simultaneous push and pop leaves `count` unchanged and moves both pointers.
- **Cache outputs:**
  - `stb2dcache_addr/wdata/sel` are driven combinationally from `entry[rd_ptr]`.
  - They are valid only while `stb2dcache_req` is 1.
- **req_q next value:**
  - If `stb_initial_read`, or `count_next` is not 0: `req_q` becomes 1.
  - Otherwise `req_q` becomes 0.
  - Each request/ack pair consumes exactly the current head entry.
- **Error:** `err_q` is set, and holds until reset, on either of:
  - `stb_wr_en` while `stb_full`;
  - `stb_r_en` while `stb_empty` or `req_q` is 0.

  The offending operation is ignored: no pointer, count or memory change.
- **Flags:** `stb_full` and `stb_empty` are decoded combinationally from `count`.

## Timing
- **Reset (async assert, sync release):**
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `req_q` = 0, `err_q` = 0.
  - All entries cleared to 0.
  - Outputs:
    - `stb_empty` = 1, `stb_full` = 0, `stb_count` = 0;
    - `stb2dcache_req` = `stb2dcache_w_en` = 0;
    - `stb2dcache_addr/wdata/sel` = 0;
    - `stb_err` = 0.
  - A reset mid-operation discards all entries and drops the outstanding request in the same cycle.
- **Push latency:**
  - Entry visible in `stb_count`/flags one cycle after the push edge.
  - Into an empty buffer, `stb2dcache_req` rises on the same edge, i.e. 1 cycle after `stb_wr_en`.
- **Pop:**
  - On the edge where the pop is taken, the next head appears on the cache outputs.
  - `stb2dcache_req` stays high if entries remain, with no bubble; it falls on that edge if the buffer becomes empty.
- **Full boundary:**
  - With `count = DEPTH`, a push together with a pop is rejected, because the push is gated by `stb_full`. The pop proceeds, `count` becomes `DEPTH-1`, and `err_q` is set.
- **Empty boundary:**
  - With `count = 0`, a push is accepted.
  - A pop in the same cycle is an error (`req_q` = 0) and is ignored.
- **Throughput:** one push and one pop per cycle maximum.

## Test plan
- Reset, then push A=0x100/D=0xAA/sel=0xF with `stb_initial_read`: next cycle `stb_count`=1, `stb_empty`=0, `stb2dcache_req`=1, `stb2dcache_addr`=0x100.
- Push 8 stores (`DEPTH`=8) with no pop: `stb_full`=1 and `stb_count`=8; a 9th `stb_wr_en` sets `stb_err`=1 with count still 8 and head unchanged.
- Fill to 3 entries, then pop three times on consecutive cycles: addresses appear in push order, `stb2dcache_req` stays high without gaps, and drops together with `stb_empty` rising after the third pop.
- Simultaneous push and pop at count=4 for 10 cycles: count stays 4, pointers wrap past 7→0, and data order is preserved.
- `stb_r_en` on an empty buffer: `stb_err`=1, count 0, pointers unchanged.
- Assert `rst_n`=0 mid-drain with 5 entries: outputs immediately return to reset values; after release, `stb_empty`=1 and the next push lands at index 0.
